// File: rtl/mem_stage.sv
// Memory-access stage downstream of the EX/MEM register: performs load/store
// handshakes on the data-memory port, stalls upstream and emits a writeback record.
module mem_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid_in,
    input  logic        load_in,
    input  logic        store_in,
    input  logic [15:0] mem_addr_in,
    input  logic [2:0]  rdest_addr_in,
    input  logic [31:0] rdest_data_in,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [2:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        err
);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    localparam bit          TIMEOUT_EN   = (TIMEOUT != 0);
    localparam logic [15:0] TIMEOUT_LAST = TIMEOUT_EN ? 16'(TIMEOUT - 1) : 16'd0;

    state_t      state_q, state_d;
    logic        op_store_q, op_store_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  rdest_q, rdest_d;
    logic [15:0] cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic        wb_valid_q, wb_valid_d;
    logic [2:0]  wb_addr_q, wb_addr_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        err_q, err_d;

    always_comb begin
        state_d    = state_q;
        op_store_d = op_store_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdest_d    = rdest_q;
        cnt_d      = cnt_q;
        wb_valid_d = 1'b0;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        err_d      = err_q;

        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    if (load_in || store_in) begin
                        // Store wins when both flags are set, so no writeback follows.
                        state_d    = ACCESS;
                        op_store_d = store_in;
                        addr_d     = mem_addr_in;
                        wdata_d    = rdest_data_in;
                        rdest_d    = rdest_addr_in;
                        cnt_d      = 16'd0;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_addr_d  = rdest_addr_in;
                        wb_data_d  = rdest_data_in;
                    end
                end
            end
            ACCESS: begin
                if (dmem_ack) begin
                    state_d = IDLE;
                    if (!op_store_q) begin
                        wb_valid_d = 1'b1;
                        wb_addr_d  = rdest_q;
                        wb_data_d  = dmem_rdata;
                    end
                end else if (TIMEOUT_EN && cnt_q == TIMEOUT_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request strobes are registered from the next state so they track ACCESS exactly.
    assign req_d = (state_d == ACCESS);
    assign we_d  = (state_d == ACCESS) && op_store_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            op_store_q <= 1'b0;
            addr_q     <= 16'h0000;
            wdata_q    <= 32'h0;
            rdest_q    <= 3'h0;
            cnt_q      <= 16'd0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= 3'h0;
            wb_data_q  <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_store_q <= op_store_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdest_q    <= rdest_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            err_q      <= err_d;
        end
    end

    assign stall      = (state_q == ACCESS);
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign wb_valid   = wb_valid_q;
    assign wb_addr    = wb_addr_q;
    assign wb_data    = wb_data_q;
    assign err        = err_q;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage sitting directly downstream of the EX-to-MEM pipeline register. It consumes that register's outputs (address, destination register, data, store flag) plus a valid bit and a load flag carried alongside them. It performs load/store transactions on the data-memory port with a req/ack handshake, and stalls the upstream pipeline while a transaction is outstanding. It produces a registered single-cycle writeback record for the register file.

## Interface
- TIMEOUT, 16: max cycles in ACCESS before abort; 0 disables timeout; legal range 0..65535.

- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- valid_in  in  1  EX/MEM register holds a live instruction
- load_in  in  1  instruction is a load
- store_in  in  1  instruction is a store
- mem_addr_in  in  16  memory address
- rdest_addr_in  in  3  destination register index
- rdest_data_in  in  32  ALU result, or store data for stores
- stall  out  1  high = upstream must hold; drives EX/MEM write enable as ~stall
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  16  memory address
- dmem_wdata  out  32  store data
- dmem_ack  in  1  memory completes current request; dmem_rdata valid same cycle for reads
- dmem_rdata  in  32  read data
- wb_valid  out  1  writeback record valid (one-cycle pulse)
- wb_addr  out  3  writeback register index
- wb_data  out  32  writeback data
- err  out  1  sticky timeout flag

## Operation
- FSM states: IDLE, ACCESS.
- IDLE, with valid_in=0: no action. wb_valid=0 next cycle.
- IDLE, with valid_in=1 and load_in=0 and store_in=0: pass-through. Next cycle wb_valid=1, wb_addr=rdest_addr_in, wb_data=rdest_data_in. State stays IDLE.
- IDLE, with valid_in=1 and (load_in or store_in): capture addr, data, rdest, and op into internal regs. Go to ACCESS. Clear the timeout counter. If both load_in and store_in are set, store has priority and no writeback occurs.
- ACCESS:
  - dmem_req=1.
  - dmem_we=1 for store.
  - dmem_addr and dmem_wdata are driven from the captured regs and stay stable until ack or abort.
  - stall=1.
- ACCESS with dmem_ack=1:
  - For a load: next cycle wb_valid=1, wb_addr=captured rdest, wb_data=dmem_rdata sampled at the ack edge.
  - For a store: wb_valid=0.
  - Go to IDLE.
- ACCESS with dmem_ack=0: the counter increments. When TIMEOUT≠0 and the counter reaches TIMEOUT-1 without ack:
  - Abort and go to IDLE.
  - Set err=1.
  - No writeback.
  - The aborted transaction is dropped.
- dmem_ack while dmem_req=0 is ignored.
- err is sticky. Only resetn clears it.
- stall = (state==ACCESS), decoded from registered state. It stays high through the ack cycle, so the EX/MEM register does not advance until the instruction following the memory op can be consumed in IDLE.
- wb_valid, wb_addr, and wb_data are registered. wb_addr and wb_data hold their last value when wb_valid=0.

## Timing
- Reset values of all outputs:
  - state IDLE
  - stall=0
  - dmem_req=0
  - dmem_we=0
  - dmem_addr=16'h0000
  - dmem_wdata=32'h0
  - wb_valid=0
  - wb_addr=3'h0
  - wb_data=32'h0
  - err=0
  - counter=0
- ALU pass-through: accepted at edge N, wb_valid high in cycle N+1.
- Load or store: accepted at edge N, dmem_req high from cycle N+1. With ack in cycle N+k (k≥1), state returns to IDLE at edge N+k. For loads, wb_valid is high in cycle N+k+1. Minimum load-to-writeback latency is 2 cycles.
- Back-to-back memory ops: the second op is accepted in the first IDLE cycle after completion. There is at least one IDLE cycle between transactions.
- Timeout: with TIMEOUT=T and no ack, dmem_req is high for exactly T cycles. err rises the cycle after the last req cycle.
- Reset asserted mid-ACCESS: dmem_req and stall drop immediately (asynchronously). Captured state is discarded and no writeback is produced.

## Test plan
- Reset then ALU op: valid_in=1, load=0, store=0, rdest=3, data=32'hDEADBEEF. Next cycle: wb_valid=1, wb_addr=3, wb_data=32'hDEADBEEF, stall=0.
- Store: addr=16'h0040, data=32'h12345678, ack after 3 cycles. Required: dmem_req/we high for 3 cycles with addr=0040 and wdata=12345678, stall high for the same 3 cycles, then no wb_valid.
- Load with immediate ack: addr=16'h0100, rdest=5, ack in the first req cycle with rdata=32'hCAFEF00D. Required: wb_valid=1, wb_addr=5, wb_data=CAFEF00D two cycles after accept.
- Load followed by a waiting ALU op (rdest=2, data=7) held in the EX/MEM register during stall. Required: the ALU op is consumed exactly once in the IDLE cycle after load completion, and its wb_valid comes one cycle after the load's wb_valid.
- Timeout with TIMEOUT=4 and ack held low. Required: dmem_req high 4 cycles, then err=1, no writeback. A subsequent load completes normally and err stays 1.
- resetn pulsed low during ACCESS. Required: dmem_req=0, stall=0, err=0 immediately. No wb_valid after release.
